// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared encodings and default geometry for the 8Queen LIFO
//               stack and its initiator-side controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int DEPTH_DEFAULT   = 8;
    localparam int WIDTH_DEFAULT   = 6;
    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_UNF = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/stack_master_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_master_if
// Description : Command/response and stack-side signal bundle for stack_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_master_if
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_op;
    logic [WIDTH-1:0]   cmd_data;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic [1:0]         rsp_err;
    logic [c_LVL_W-1:0] level;
    logic               user_push;
    logic               user_pop;
    logic [WIDTH-1:0]   bus_in;
    logic [WIDTH-1:0]   bus_out;
    logic               overflow;
    logic               underflow;
    logic               ready;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, bus_out, overflow, underflow, ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, level,
               user_push, user_pop, bus_in
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, bus_out, overflow, underflow, ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, level,
               user_push, user_pop, bus_in
    );

endinterface
`default_nettype wire

// File: rtl/stack_level_counter.sv
`default_nettype none
// ============================================================================
// Module      : stack_level_counter
// Description : Saturating up/down occupancy mirror with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_level_counter
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_inc,
    input  logic                       i_dec,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [c_LVL_W-1:0] r_level;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_level == c_LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_level <= r_level + 1'b1;
        end else if (i_dec && !i_inc && !w_empty) begin
            r_level <= r_level - 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/stack_master.sv
`default_nettype none
// ============================================================================
// Module      : stack_master
// Description : Initiator-side controller for the LIFO stack: one command in
//               flight, local over/underflow rejection, timeout on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_master
    import stack_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    stack_master_if.master bus
);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_op;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_rdata;
    logic [1:0]         r_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_last;
    logic               w_ok;
    logic [c_LVL_W-1:0] w_level;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid && bus.ready;
    assign w_last   = (r_cnt == c_CNT_W'(TIMEOUT - 1));
    assign w_ok     = (r_state == ST_RESP) && (r_err == ERR_OK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = 1'b0;
        bus.user_push = 1'b0;
        bus.user_pop  = 1'b0;
        bus.bus_in    = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = ERR_OK;
        bus.rsp_data  = '0;
        case (r_state)
            ST_IDLE: begin
                // Gate with reset so cmd_ready is 0 while reset is held.
                bus.cmd_ready = bus.ready && !reset;
                if (w_accept) begin
                    if ((bus.cmd_op == OP_PUSH && w_full) ||
                        (bus.cmd_op == OP_POP && w_empty)) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                bus.user_push = (r_op == OP_PUSH);
                bus.user_pop  = (r_op == OP_POP);
                bus.bus_in    = r_data;
                w_next        = ST_WAIT;
            end
            ST_WAIT: begin
                bus.bus_in = r_data;
                if (bus.ready || w_last) begin
                    w_next = ST_RESP;
                end
            end
            default: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_data  = (w_ok && r_op == OP_POP) ? r_rdata : '0;
                w_next        = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_PUSH;
            r_data  <= '0;
            r_rdata <= '0;
            r_err   <= ERR_OK;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.cmd_op;
                        r_data  <= bus.cmd_data;
                        r_rdata <= '0;
                        if (bus.cmd_op == OP_PUSH && w_full) begin
                            r_err <= ERR_OVF;
                        end else if (bus.cmd_op == OP_POP && w_empty) begin
                            r_err <= ERR_UNF;
                        end else begin
                            r_err <= ERR_OK;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // Completion wins over timeout if both land on the same cycle.
                    if (bus.ready) begin
                        r_rdata <= bus.bus_out;
                        if (bus.overflow) begin
                            r_err <= ERR_OVF;
                        end else if (bus.underflow) begin
                            r_err <= ERR_UNF;
                        end else begin
                            r_err <= ERR_OK;
                        end
                    end else if (w_last) begin
                        r_err <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    stack_level_counter #(
        .DEPTH (DEPTH)
    ) u_level (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_ok && r_op == OP_PUSH),
        .i_dec   (w_ok && r_op == OP_POP),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_stack_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_master
// Description : Self-checking bench for stack_master against a behavioural
//               LIFO stub with a stall mode that withholds ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_master;
    import stack_pkg::*;

    localparam int c_DEPTH   = 8;
    localparam int c_WIDTH   = 6;
    localparam int c_TIMEOUT = 16;

    typedef struct packed {
        logic [1:0] err;
        logic [5:0] data;
    } exp_t;

    logic clk;
    logic reset;
    bit   stall;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    stack_master_if #(.DEPTH(c_DEPTH), .WIDTH(c_WIDTH)) sif ();

    stack_master #(
        .DEPTH   (c_DEPTH),
        .WIDTH   (c_WIDTH),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LIFO stub sharing the controller's reset.
    logic [5:0] mem [8];
    logic [3:0] sp;
    logic [3:0] sp_m1;
    assign sp_m1 = sp - 4'd1;

    always @(posedge clk) begin
        if (reset) begin
            sp            <= 4'd0;
            sif.ready     <= 1'b1;
            sif.overflow  <= 1'b0;
            sif.underflow <= 1'b0;
            sif.bus_out   <= '0;
        end else begin
            if (!stall) begin
                sif.ready <= 1'b1;
            end else if (sif.user_push || sif.user_pop) begin
                sif.ready <= 1'b0;
            end
            if (!stall && sif.user_push) begin
                if (sp == 4'd8) begin
                    sif.overflow <= 1'b1;
                end else begin
                    mem[sp[2:0]] <= sif.bus_in;
                    sp           <= sp + 4'd1;
                    sif.overflow <= 1'b0;
                end
            end
            if (!stall && sif.user_pop) begin
                if (sp == 4'd0) begin
                    sif.underflow <= 1'b1;
                end else begin
                    sif.bus_out   <= mem[sp_m1[2:0]];
                    sp            <= sp_m1;
                    sif.underflow <= 1'b0;
                end
            end
        end
    end

    // Drive one command and wait (bounded) for its response; call at a negedge.
    task automatic issue(input logic op, input logic [5:0] d,
                         output logic [5:0] rd, output logic [1:0] er,
                         output int lat, output int npush, output int npop);
        int n;
        n = 0;
        while (!sif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_data  = d;
        @(posedge clk);
        #1;
        sif.cmd_valid = 1'b0;
        lat   = 0;
        npush = 0;
        npop  = 0;
        rd    = '0;
        er    = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sif.user_push) npush++;
            if (sif.user_pop)  npop++;
            if (sif.rsp_valid) begin
                lat = i;
                rd  = sif.rsp_data;
                er  = sif.rsp_err;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.level, sif.user_push,
             sif.user_pop, sif.bus_in, sif.cmd_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv=%0b rd=%0d re=%0d lvl=%0d up=%0b po=%0b bi=%0d cr=%0b, expected all 0",
                     sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.level, sif.user_push,
                     sif.user_pop, sif.bus_in, sif.cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_push_fill();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{err: ERR_OK, data: 6'd0});
            issue(OP_PUSH, 6'(k), rd, er, lat, np, nq);
            e = sb.pop_front();
            vectors++;
            if (er !== e.err || rd !== e.data || lat != 3 || np != 1 || nq != 0) begin
                miscompares++;
                $display("FAIL push_fill[%0d]: got err=%0d data=%0d lat=%0d push=%0d pop=%0d, expected err=%0d data=%0d lat=3 push=1 pop=0",
                         k, er, rd, lat, np, nq, e.err, e.data);
            end
        end
        vectors++;
        if (sif.level !== 4'd8) begin
            miscompares++;
            $display("FAIL push_fill_level: got %0d expected 8", sif.level);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq;
        exp_t e;
        sb.push_back('{err: ERR_OVF, data: 6'd0});
        issue(OP_PUSH, 6'd8, rd, er, lat, np, nq);
        e = sb.pop_front();
        vectors++;
        if (er !== e.err || rd !== e.data || lat != 1 || np != 0 || sif.level !== 4'd8) begin
            miscompares++;
            $display("FAIL overflow_reject: got err=%0d data=%0d lat=%0d push=%0d lvl=%0d, expected err=1 data=0 lat=1 push=0 lvl=8",
                     er, rd, lat, np, sif.level);
        end
    endtask

    task automatic test_pop_drain();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq;
        exp_t e;
        for (int k = 7; k >= 0; k--) begin
            sb.push_back('{err: ERR_OK, data: 6'(k)});
            issue(OP_POP, 6'd0, rd, er, lat, np, nq);
            e = sb.pop_front();
            vectors++;
            if (er !== e.err || rd !== e.data || lat != 3 || np != 0 || nq != 1) begin
                miscompares++;
                $display("FAIL pop_drain[%0d]: got err=%0d data=%0d lat=%0d push=%0d pop=%0d, expected err=%0d data=%0d lat=3 push=0 pop=1",
                         k, er, rd, lat, np, nq, e.err, e.data);
            end
        end
        vectors++;
        if (sif.level !== 4'd0) begin
            miscompares++;
            $display("FAIL pop_drain_level: got %0d expected 0", sif.level);
        end
        sb.push_back('{err: ERR_UNF, data: 6'd0});
        issue(OP_POP, 6'd0, rd, er, lat, np, nq);
        e = sb.pop_front();
        vectors++;
        if (er !== e.err || rd !== e.data || lat != 1 || nq != 0 || sif.level !== 4'd0) begin
            miscompares++;
            $display("FAIL underflow_reject: got err=%0d data=%0d lat=%0d pop=%0d lvl=%0d, expected err=2 data=0 lat=1 pop=0 lvl=0",
                     er, rd, lat, nq, sif.level);
        end
    endtask

    task automatic test_mixed();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq;
        exp_t e;
        logic       ops  [16];
        logic [5:0] dats [16];
        logic [5:0] exps [16];
        ops  = '{0,0,0,0,0,0, 1,1, 0,0,0,0, 1,1,1,1};
        dats = '{0,1,2,3,4,5, 0,0, 6,7,8,9, 0,0,0,0};
        exps = '{0,0,0,0,0,0, 5,4, 0,0,0,0, 9,8,7,6};
        for (int k = 0; k < 16; k++) begin
            sb.push_back('{err: ERR_OK, data: exps[k]});
            issue(ops[k], dats[k], rd, er, lat, np, nq);
            e = sb.pop_front();
            vectors++;
            if (er !== e.err || rd !== e.data || lat != 3) begin
                miscompares++;
                $display("FAIL mixed[%0d]: got err=%0d data=%0d lat=%0d, expected err=%0d data=%0d lat=3",
                         k, er, rd, lat, e.err, e.data);
            end
        end
        vectors++;
        if (sif.level !== 4'd4) begin
            miscompares++;
            $display("FAIL mixed_level: got %0d expected 4", sif.level);
        end
    endtask

    task automatic test_timeout();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq;
        exp_t e;
        stall = 1'b1;
        sb.push_back('{err: ERR_TMO, data: 6'd0});
        issue(OP_PUSH, 6'd33, rd, er, lat, np, nq);
        e = sb.pop_front();
        // ISSUE is cycle 1, WAIT starts at cycle 2, RESP follows TIMEOUT cycles later.
        vectors++;
        if (er !== e.err || rd !== e.data || lat != c_TIMEOUT + 2 || np != 1) begin
            miscompares++;
            $display("FAIL timeout_rsp: got err=%0d data=%0d lat=%0d push=%0d, expected err=3 data=0 lat=%0d push=1",
                     er, rd, lat, np, c_TIMEOUT + 2);
        end
        vectors++;
        if (sif.level !== 4'd4 || dut.r_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL timeout_after: got lvl=%0d state=%0d, expected lvl=4 state=0",
                     sif.level, dut.r_state);
        end
        stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [5:0] rd;
        logic [1:0] er;
        int lat, np, nq, seen;
        exp_t e;
        stall = 1'b1;
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = OP_PUSH;
        sif.cmd_data  = 6'd21;
        @(posedge clk);
        #1;
        sif.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (dut.r_state !== ST_WAIT) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got state=%0d expected 2", dut.r_state);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.level, sif.user_push,
             sif.user_pop, sif.bus_in, sif.cmd_ready} !== '0 || dut.r_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got rv=%0b lvl=%0d bi=%0d cr=%0b state=%0d, expected all 0",
                     sif.rsp_valid, sif.level, sif.bus_in, sif.cmd_ready, dut.r_state);
        end
        reset = 1'b0;
        stall = 1'b0;
        seen  = 0;
        repeat (4) begin
            @(negedge clk);
            if (sif.rsp_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_rsp: got %0d responses expected 0", seen);
        end
        sb.push_back('{err: ERR_OK, data: 6'd0});
        issue(OP_PUSH, 6'd21, rd, er, lat, np, nq);
        e = sb.pop_front();
        vectors++;
        if (er !== e.err || rd !== e.data || lat != 3 || sif.level !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_mid_push: got err=%0d data=%0d lat=%0d lvl=%0d, expected err=0 data=0 lat=3 lvl=1",
                     er, rd, lat, sif.level);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        stall         = 1'b0;
        reset         = 1'b1;
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = 1'b0;
        sif.cmd_data  = '0;
        @(negedge clk);
        test_reset();
        test_push_fill();
        test_overflow();
        test_pop_drain();
        test_mixed();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_master.md
Name: stack_master

Overview:
- Initiator-side controller for the 8Queen LIFO stack. It sits between a solver or sequencer and the stack.
- Accepts push/pop commands on a valid/ready interface, drives the stack's push/pop strobes and data bus, and waits for stack completion.
- Returns one response per command: popped data plus an error code.
- Mirrors stack occupancy locally, so impossible operations are rejected without touching the stack.

Parameters:
DEPTH, 8, stack capacity in entries; must match the attached stack.
WIDTH, 6, data word width; must match the attached stack.
TIMEOUT, 16, maximum cycles spent in WAIT before the command is abandoned.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  upstream command present.
cmd_ready  output  1  block can accept a command this cycle.
cmd_op  input  1  0 = push, 1 = pop.
cmd_data  input  WIDTH  push payload; ignored for pop.
rsp_valid  output  1  one-cycle response strobe.
rsp_data  output  WIDTH  popped word; 0 for push or on error.
rsp_err  output  2  0 ok, 1 overflow, 2 underflow, 3 timeout.
level  output  clog2(DEPTH+1)  mirrored occupancy.
user_push  output  1  push strobe to stack.
user_pop  output  1  pop strobe to stack.
bus_in  output  WIDTH  data to stack.
bus_out  input  WIDTH  data from stack.
overflow  input  1  stack overflow flag.
underflow  input  1  stack underflow flag.
ready  input  1  stack idle/complete.

Behaviour:
- Reset value of every output is 0. Reset also forces state to IDLE and clears level and the timeout counter.
- Reset mid-operation abandons the command with no response. The stack must share the same reset.
- States:
  - IDLE: cmd_ready = ready. On cmd_valid & cmd_ready, latch op and data (cycle T).
    - Push with level==DEPTH goes to RESP with err 1.
    - Pop with level==0 goes to RESP with err 2.
    - Otherwise go to ISSUE.
  - ISSUE (T+1): exactly one of user_push/user_pop high for this single cycle. bus_in drives the latched data from ISSUE through WAIT. Go to WAIT and clear the counter.
  - WAIT: counter increments each cycle.
    - On the first cycle with ready==1, capture bus_out, overflow and underflow, then go to RESP.
    - If the counter reaches TIMEOUT-1 without ready, go to RESP with err 3.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready=0 in RESP.
- Error precedence on completion: captured overflow gives err 1, else captured underflow gives err 2, else err 0.
- level update happens in the RESP cycle, only on err 0: push +1, pop -1. Errors leave level unchanged.
- Strobes are never asserted outside ISSUE. No second command is issued before RESP.
- Latency:
  - Stack operation: minimum rsp_valid at T+3 (ready high at T+2).
  - Local reject: rsp_valid at T+1.
- Throughput: at most one command per 4 cycles.
- rsp_data is the captured bus_out for a successful pop, else 0.
- level saturates at 0..DEPTH by construction. No wrap.
- cmd_valid while cmd_ready=0 is held off. Upstream keeps cmd_* stable until accepted.

Decomposition:
- Shared package stack_pkg:
  - op encodings OP_PUSH=0, OP_POP=1;
  - error codes ERR_OK/ERR_OVF/ERR_UNF/ERR_TMO;
  - state encoding for IDLE/ISSUE/WAIT/RESP;
  - default DEPTH/WIDTH shared with the stack.
- One natural sub-module: stack_level_counter, an up/down saturating occupancy mirror with full/empty outputs. The FSM stays in stack_master.

Test Plan:
1. Reset, then push 0..7 back-to-back against an 8-deep stack. Expect 8 responses with err 0, level 8, user_push high exactly 1 cycle per command.
2. Ninth push of 8 at level 8. Expect rsp_valid at T+1, err 1, user_push never asserted, level stays 8.
3. Pop 8 times. Expect rsp_data 7,6,...,0 with err 0 and level 0. A further pop gives err 2 at T+1 with no user_pop.
4. Push 0..5, pop 2 (data 5,4), push 6..9, pop 4. Expect data 9,8,7,6 and final level 4.
5. Stub stack holding ready low after a push. Expect rsp_err 3 exactly TIMEOUT cycles after WAIT entry, level unchanged, return to IDLE.
6. Assert reset during WAIT. Next cycle all outputs are 0, level 0, state IDLE, no rsp_valid. A subsequent push completes with err 0.
